// File: rtl/carfield_domain_clkdiv_ctrl.sv
// Per-domain clock-enable strobe generator with runtime-programmable divisors.
// Define CARFIELD_CLKDIV_SAFE_UPDATE_EN to defer divisor commits to the target's period boundary.
module carfield_domain_clkdiv_ctrl #(
   parameter int NumDomains = 6,
   parameter int DivWidth   = 8,
   parameter int DefaultDiv = 1,
   parameter int IdxWidth   = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumDomains-1:0]          domain_en_i,
   input  logic                           cfg_valid_i,
   output logic                           cfg_ready_o,
   input  logic [IdxWidth-1:0]            cfg_domain_i,
   input  logic [DivWidth-1:0]            cfg_div_i,
   output logic [NumDomains-1:0]          clk_en_o,
   output logic [NumDomains*DivWidth-1:0] div_o,
   output logic                           busy_o,
   output logic                           err_o
);

   localparam logic [DivWidth-1:0] DEF_DIV = DivWidth'(DefaultDiv);
   localparam logic [DivWidth-1:0] ONE     = DivWidth'(1);

   logic [DivWidth-1:0]           r_div [NumDomains];
   logic [DivWidth-1:0]           r_cnt [NumDomains];
   logic [NumDomains-1:0]         r_clk_en;
   logic                          r_err;

   logic [NumDomains-1:0]         w_wrap;
   logic [NumDomains-1:0]         w_commit;
   logic                          w_fire;
   logic                          w_bad;
   logic                          w_do_commit;
   logic [IdxWidth-1:0]           w_tgt;
   logic [DivWidth-1:0]           w_new_div;
   logic [NumDomains*DivWidth-1:0] w_div_flat;

   assign w_fire = cfg_valid_i && cfg_ready_o;
   assign w_bad  = (cfg_div_i == '0) || (32'(cfg_domain_i) >= NumDomains);

   always_comb begin
      w_wrap = '0;
      for (int k = 0; k < NumDomains; k++) begin
         w_wrap[k] = (r_cnt[k] == (r_div[k] - ONE));
      end
   end

`ifdef CARFIELD_CLKDIV_SAFE_UPDATE_EN
   typedef enum logic {S_IDLE, S_PENDING} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IdxWidth-1:0] r_pend_dom;
   logic [DivWidth-1:0] r_pend_div;
   logic                w_tgt_hit;

   // The pending commit fires where the target's current period ends, or at once if it is stopped.
   always_comb begin
      w_tgt_hit = 1'b0;
      for (int k = 0; k < NumDomains; k++) begin
         if (r_pend_dom == IdxWidth'(k)) begin
            w_tgt_hit = w_wrap[k] || !domain_en_i[k];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_do_commit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fire && !w_bad) begin
               w_state_nxt = S_PENDING;
            end
         end
         S_PENDING: begin
            if (w_tgt_hit) begin
               w_do_commit = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (r_state == S_IDLE && w_fire && !w_bad) begin
         r_pend_dom <= cfg_domain_i;
         r_pend_div <= cfg_div_i;
      end
   end

   assign w_tgt       = r_pend_dom;
   assign w_new_div   = r_pend_div;
   assign cfg_ready_o = (r_state == S_IDLE);
   assign busy_o      = (r_state == S_PENDING);
`else
   assign w_do_commit = w_fire && !w_bad;
   assign w_tgt       = cfg_domain_i;
   assign w_new_div   = cfg_div_i;
   assign cfg_ready_o = 1'b1;
   assign busy_o      = 1'b0;
`endif

   always_comb begin
      w_commit = '0;
      for (int k = 0; k < NumDomains; k++) begin
         w_commit[k] = w_do_commit && (w_tgt == IdxWidth'(k));
      end
   end

   // Strobe is registered from the pre-edge counter, so the period in flight still ends cleanly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_clk_en <= '0;
         r_err    <= 1'b0;
         for (int k = 0; k < NumDomains; k++) begin
            r_div[k] <= DEF_DIV;
            r_cnt[k] <= '0;
         end
      end else begin
         r_err <= w_fire && w_bad;
         for (int k = 0; k < NumDomains; k++) begin
            r_clk_en[k] <= domain_en_i[k] && w_wrap[k];
            if (w_commit[k]) begin
               r_div[k] <= w_new_div;
            end
            if (!domain_en_i[k] || w_commit[k] || w_wrap[k]) begin
               r_cnt[k] <= '0;
            end else begin
               r_cnt[k] <= r_cnt[k] + ONE;
            end
         end
      end
   end

   always_comb begin
      w_div_flat = '0;
      for (int k = 0; k < NumDomains; k++) begin
         w_div_flat[k*DivWidth +: DivWidth] = r_div[k];
      end
   end

   assign div_o    = w_div_flat;
   assign clk_en_o = r_clk_en;
   assign err_o    = r_err;

endmodule

// File: tb/tb_carfield_domain_clkdiv_ctrl.sv
// Directed bench for carfield_domain_clkdiv_ctrl with hand-computed expectations.
module tb_carfield_domain_clkdiv_ctrl;

   localparam int ND = 6;
   localparam int DW = 8;
   localparam int IW = 3;
`ifdef CARFIELD_CLKDIV_SAFE_UPDATE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_i;
   logic [ND-1:0]    domain_en_i;
   logic             cfg_valid_i;
   logic             cfg_ready_o;
   logic [IW-1:0]    cfg_domain_i;
   logic [DW-1:0]    cfg_div_i;
   logic [ND-1:0]    clk_en_o;
   logic [ND*DW-1:0] div_o;
   logic             busy_o;
   logic             err_o;

   int n_chk  = 0;
   int n_pass = 0;

   carfield_domain_clkdiv_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .domain_en_i  (domain_en_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_domain_i (cfg_domain_i),
      .cfg_div_i    (cfg_div_i),
      .clk_en_o     (clk_en_o),
      .div_o        (div_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int dom, input int dv);
      cfg_valid_i  = 1'b1;
      cfg_domain_i = IW'(dom);
      cfg_div_i    = DW'(dv);
      tick();
      cfg_valid_i  = 1'b0;
   endtask

   // Returns once a strobe on domain d has been sampled; that domain's counter is then 0.
   task automatic wait_strobe(input int d, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (clk_en_o[d]) seen = 1'b1;
      end
      chk(tag, seen, 1'b1);
   endtask

   initial begin
      int strobes;
      logic [ND-1:0] exp_en;
      rst_i        = 1'b1;
      domain_en_i  = '1;
      cfg_valid_i  = 1'b0;
      cfg_domain_i = '0;
      cfg_div_i    = '0;
      tick();
      tick();
      chk("rst_clk_en", clk_en_o, 6'h00);
      chk("rst_err", err_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_ready", cfg_ready_o, 1'b1);
      chk("rst_div", div_o, 48'h010101010101);

      rst_i = 1'b0;
      tick();
      chk("div1_en_a", clk_en_o, 6'h3f);
      tick();
      chk("div1_en_b", clk_en_o, 6'h3f);

      // domain 2 -> div 4
      cfg(2, 4);
      for (int i = 1; i <= 8; i++) begin
         int j;
         tick();
         j = i - LAT;
         exp_en = ((j <= 0) || (j % 4 == 0)) ? 6'h3f : 6'h3b;
         chk($sformatf("d2_div4_c%0d", i), clk_en_o, exp_en);
      end
      chk("d2_div_o", div_o, 48'h010101040101);

      // rejected requests
      cfg(1, 0);
      chk("err_div0", err_o, 1'b1);
      tick();
      chk("err_div0_clr", err_o, 1'b0);
      cfg(7, 3);
      chk("err_dom7", err_o, 1'b1);
      tick();
      chk("err_dom7_clr", err_o, 1'b0);
      chk("err_div_o", div_o, 48'h010101040101);

      // domain 0: div 5, then request div 2 at cnt == 1
      cfg(0, 5);
      tick();
      tick();
      wait_strobe(0, "d0_strobe_seen");
      tick();
      cfg(0, 2);
`ifdef CARFIELD_CLKDIV_SAFE_UPDATE_EN
      chk("upd_busy_e0", busy_o, 1'b1);
      chk("upd_ready_e0", cfg_ready_o, 1'b0);
      tick();
      chk("upd_busy_e1", busy_o, 1'b1);
      tick();
      chk("upd_busy_e2", busy_o, 1'b1);
      chk("upd_div_old", div_o[7:0], 8'd5);
      tick();
      chk("upd_busy_e3", busy_o, 1'b0);
      chk("upd_ready_e3", cfg_ready_o, 1'b1);
      chk("upd_div_e3", div_o[7:0], 8'd2);
      chk("upd_old_strobe", clk_en_o[0], 1'b1);
      tick();
      chk("upd_en_e4", clk_en_o[0], 1'b0);
      tick();
      chk("upd_en_e5", clk_en_o[0], 1'b1);
`else
      chk("upd_busy_e0", busy_o, 1'b0);
      chk("upd_ready_e0", cfg_ready_o, 1'b1);
      chk("upd_div_e0", div_o[7:0], 8'd2);
      chk("upd_en_e0", clk_en_o[0], 1'b0);
      tick();
      chk("upd_en_e1", clk_en_o[0], 1'b0);
      tick();
      chk("upd_en_e2", clk_en_o[0], 1'b1);
      tick();
      chk("upd_en_e3", clk_en_o[0], 1'b0);
      tick();
      chk("upd_en_e4", clk_en_o[0], 1'b1);
`endif

      // domain 3: div 3, drop enable mid-period
      cfg(3, 3);
      tick();
      tick();
      wait_strobe(3, "d3_strobe_seen");
      tick();
      domain_en_i[3] = 1'b0;
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (clk_en_o[3]) strobes++;
      end
      chk("d3_off_strobes", strobes, 0);
      domain_en_i[3] = 1'b1;
      tick();
      chk("d3_reen_c1", clk_en_o[3], 1'b0);
      tick();
      chk("d3_reen_c2", clk_en_o[3], 1'b0);
      tick();
      chk("d3_reen_c3", clk_en_o[3], 1'b1);

      // reset while an update may be pending
      cfg(3, 7);
`ifdef CARFIELD_CLKDIV_SAFE_UPDATE_EN
      chk("pend_busy", busy_o, 1'b1);
`endif
      rst_i = 1'b1;
      tick();
      chk("rst2_busy", busy_o, 1'b0);
      chk("rst2_ready", cfg_ready_o, 1'b1);
      chk("rst2_div", div_o, 48'h010101010101);
      chk("rst2_clk_en", clk_en_o, 6'h00);
      rst_i = 1'b0;
      tick();
      chk("rst2_run", clk_en_o, 6'h3f);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", n_chk, 0);
      $fatal(1, "timeout");
   end

endmodule
